// File: rtl/uart_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with a valid/ready byte output, start-glitch
//            rejection, framing and overrun detection. Optional even parity
//            is enabled by defining UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 5001,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t          r_state;
  logic            r_s1;
  logic            r_s2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;

  logic w_bit_done;
  logic w_half_done;
  logic w_accept;
  logic w_par_ok;

  assign w_bit_done  = (r_cnt == c_BIT_LAST);
  assign w_half_done = (r_cnt == c_HALF_LAST);
  assign w_accept    = data_valid & data_ready;

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic r_parity_err;
  // Even parity: data bits together with the parity bit must XOR to zero.
  assign w_par_ok   = ~(^{r_shift, r_par});
  assign parity_err = r_parity_err;
`else
  assign w_par_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_s1        <= 1'b1;
      r_s2        <= 1'b1;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_s1        <= rx;
      r_s2        <= r_s1;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (w_accept) begin
        data_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!r_s2) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_half_done) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            // Line back high at mid-start means a glitch, not a frame.
            r_state   <= r_s2 ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (w_bit_done) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_s2;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_par   <= r_s2;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif

        S_STOP: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (!r_s2) begin
              framing_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end else begin
              // Returning to IDLE at mid-stop lets a back-to-back start be caught.
              r_state <= S_IDLE;
              if (!w_par_ok) begin
`ifdef UART_RX_PARITY_EN
                r_parity_err <= 1'b1;
`endif
              end else if (!data_valid || w_accept) begin
                data       <= r_shift;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_WAIT_HIGH: begin
          r_cnt <= '0;
          if (r_s2) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx with a frame-level reference model.
//            Parity scenarios are included when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       framing_err;
  logic       overrun;
  logic       parity_err;

  always #5 clock = ~clock;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int n_ferr, n_ovr, n_perr, n_vcyc;
  int e_ferr, e_ovr, e_perr;

  // Observe the line away from the active edge; a byte counts as received
  // when the handshake will complete on the following rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (data_valid && data_ready) got_q.push_back(data);
      n_ferr += int'(framing_err);
      n_ovr  += int'(overrun);
      n_perr += int'(parity_err);
      n_vcyc += int'(data_valid);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    n_ferr = 0; n_ovr = 0; n_perr = 0; n_vcyc = 0;
    e_ferr = 0; e_ovr = 0; e_perr = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  // Reference model: what one frame should produce, given a ready consumer.
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic par);
    logic good_par;
`ifdef UART_RX_PARITY_EN
    good_par = ((^b) == par);
`else
    good_par = 1'b1;
`endif
    if (!stop)          e_ferr++;
    else if (!good_par) e_perr++;
    else                exp_q.push_back(b);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    check({tag, "_ferr"}, n_ferr, e_ferr);
    check({tag, "_ovr"},  n_ovr,  e_ovr);
    check({tag, "_perr"}, n_perr, e_perr);
  endtask

  initial begin
    int lat;
    int exp_lat;
    logic [7:0] b;
    logic stop, par;

    reset = 1'b1; rx = 1'b1; data_ready = 1'b1;
    clear_mon();
    repeat (4) @(negedge clock);
    check("reset_outputs", {data, data_valid, framing_err, overrun, parity_err}, 32'd0);
    reset = 1'b0;
    idle(10);

    // Single byte with latency measurement.
    clear_mon();
    exp_lat = 2 + HALF + 9 * CPB;
`ifdef UART_RX_PARITY_EN
    exp_lat += CPB;
`endif
    lat = 0;
    fork
      send_frame(8'h68, 1'b1, ^8'h68);
      begin
        while (!data_valid && lat < 400) begin
          @(negedge clock);
          lat++;
        end
      end
    join
    model_frame(8'h68, 1'b1, ^8'h68);
    idle(4);
    check("latency_window", (lat >= exp_lat - 1 && lat <= exp_lat + 1), 1);
    check("valid_one_cycle", n_vcyc, 1);
    compare_all("byte_68");

    // Short start glitch.
    clear_mon();
    rx = 1'b0;
    repeat (4) @(negedge clock);
    idle(3 * CPB);
    check("glitch_valid", n_vcyc, 0);
    compare_all("glitch");

    // Framing error with a held break, then recovery.
    clear_mon();
    send_frame(8'h55, 1'b0, ^8'h55);
    model_frame(8'h55, 1'b0, ^8'h55);
    rx = 1'b0;
    repeat (5 * CPB) @(negedge clock);
    idle(CPB);
    send_frame(8'h21, 1'b1, ^8'h21);
    model_frame(8'h21, 1'b1, ^8'h21);
    idle(4);
    compare_all("framing");

    // Overrun with a stalled consumer.
    clear_mon();
    data_ready = 1'b0;
    send_frame(8'h6C, 1'b1, ^8'h6C);
    send_frame(8'h6F, 1'b1, ^8'h6F);
    idle(8);
    check("ovr_valid_held", data_valid, 1'b1);
    check("ovr_data_held", data, 8'h6C);
    data_ready = 1'b1;
    @(negedge clock);
    idle(2);
    check("ovr_valid_clear", data_valid, 1'b0);
    exp_q.push_back(8'h6C);
    e_ovr = 1;
    compare_all("overrun");

    // Reset during bit 4 of 0x77.
    clear_mon();
    b = 8'h77;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    repeat (HALF) @(negedge clock);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_reset_outputs", {data, data_valid, framing_err, overrun, parity_err}, 32'd0);
    reset = 1'b0;
    idle(20 * CPB);
    send_frame(8'h64, 1'b1, ^8'h64);
    model_frame(8'h64, 1'b1, ^8'h64);
    idle(4);
    compare_all("reset_mid");

`ifdef UART_RX_PARITY_EN
    clear_mon();
    send_frame(8'h03, 1'b1, 1'b1);
    model_frame(8'h03, 1'b1, 1'b1);
    idle(4);
    send_frame(8'h03, 1'b1, 1'b0);
    model_frame(8'h03, 1'b1, 1'b0);
    idle(4);
    compare_all("parity");
`endif

    // Randomized frames against the model.
    clear_mon();
    for (int k = 0; k < 16; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      par  = ^b;
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 4) == 0) par = ~par;
`endif
      send_frame(b, stop, par);
      model_frame(b, stop, par);
      idle($urandom_range(3, 20));
    end
    idle(4);
    compare_all("random");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the downstream stage of the team's transmitter. Consumes the serial `tx` line and delivers bytes over a valid/ready interface.
- Fixed baud divisor; mid-bit sampling after a 2-flop synchronizer; start-bit glitch rejection; framing and overrun detection.
- Used for loopback self-test: it checks that the transmitter emits the expected byte stream ("hello world!").

Parameters:
- CLKS_PER_BIT, 5001, clock cycles per bit; matches the transmitter's 0..5000 baud counter; legal range ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer divide), cycles from the synchronized start edge to the start-bit mid-sample.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line; idle high
- data  output  8  received byte, LSB = first data bit
- data_valid  output  1  byte available; held until accepted
- data_ready  input  1  consumer accepts when data_valid & data_ready on a clock edge
- framing_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while data_valid still high
- parity_err  output  1  one-cycle pulse: parity mismatch (UART_RX_PARITY_EN only; tied 0 otherwise)

Behaviour:
- Reset: clock and reset are as above; reset acts on the rising edge of clock. All outputs go to 0. FSM=IDLE. Counters=0. Synchronizer flops=1. Reset mid-frame abandons the frame; nothing is delivered.
- Synchronizer: rx → s1 → s2. All logic uses s2, which adds 2 cycles of latency.
- Bit counter `cnt` clears on every state entry.
- Bit index `bit_idx` is 3 bits wide and runs 0..7.
- IDLE: wait for s2 == 0, then go to START.
- START: count to HALF_BIT-1.
  - If s2 == 1 at that point: glitch; return to IDLE with no flags.
  - Otherwise go to DATA with bit_idx = 0.
- DATA: when cnt == CLKS_PER_BIT-1, shift s2 into shift[bit_idx] (LSB first).
  - After bit_idx == 7, go to STOP (or PARITY when enabled).
- STOP: when cnt == CLKS_PER_BIT-1, sample s2.
  - s2 == 1 with data_valid == 0: on that same edge, data ← shift and data_valid ← 1; go to IDLE.
  - s2 == 1 with data_valid == 1: overrun pulses for 1 cycle; the new byte is dropped and data keeps the old byte; go to IDLE.
  - s2 == 0: framing_err pulses for 1 cycle; no delivery; go to WAIT_HIGH.
- WAIT_HIGH: stay until s2 == 1, then go to IDLE. A held break produces no repeated errors.
- Because IDLE is re-entered at mid-stop, a back-to-back start edge one half-bit later is caught.
- Handshake:
  - data_valid clears on the edge where data_valid & data_ready.
  - If delivery and acceptance fall on the same edge, delivery wins: data_valid stays 1 with the new byte, and no overrun is flagged.
  - data is stable while data_valid = 1.
- Latency: data_valid rises (2 + HALF_BIT + 9·CLKS_PER_BIT) cycles after the rx falling edge, ±1 cycle.
- Pulses: framing_err, overrun and parity_err are high for exactly 1 cycle and are mutually exclusive per frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, one bit long, sampled at the same mid-bit point.
  - Even parity is expected: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, parity_err pulses for 1 cycle at the stop sample and the byte is not delivered.
  - A framing error takes precedence over a parity error.
- Undefined:
  - No PARITY state; the frame is 8N1.
  - parity_err is constant 0.

Test Plan:
- CLKS_PER_BIT=16, data_ready=1; drive 0x68 as 8N1 → data=0x68, data_valid high 1 cycle; no flags.
- Drive rx low for 4 cycles, then high → FSM returns to IDLE; data_valid, framing_err and overrun stay 0.
- Drive 0x55 with the stop bit low → framing_err pulses once; data_valid stays 0; FSM holds in WAIT_HIGH until rx is high, and the next 0x21 is received correctly.
- data_ready=0; send 0x6C then 0x6F back-to-back → first delivers 0x6C; second pulses overrun; data stays 0x6C until data_ready=1.
- Assert reset during bit 4 of 0x77; release and send 0x64 → only 0x64 is delivered; all outputs are 0 during reset.
- UART_RX_PARITY_EN: send 0x03 with parity bit 1 → parity_err pulses and there is no delivery. Send 0x03 with parity bit 0 → 0x03 is delivered.
